// File: rtl/serial_subtractor_32bit_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_32bit_pkg;

   localparam int unsigned DATA_W_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

endpackage

// File: rtl/serial_subtractor_32bit_full_adder.sv
// Single-bit full adder used as the per-cycle arithmetic slice.
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor_32bit.sv
// Bit-serial a - b - bin, LSB first, one bit per clock, valid/ready on both sides.
// Optional eq/lt/ltu comparison flags when SERIAL_SUB_CMP_EN is defined.
module serial_subtractor_32bit
   import serial_subtractor_32bit_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              bin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] diff,
   output logic              bout,
   output logic              overflow
`ifdef SERIAL_SUB_CMP_EN
  ,output logic              eq,
   output logic              lt,
   output logic              ltu
`endif
);

   localparam int unsigned       IDX_W    = $clog2(DATA_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   state_t            state, state_next;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] a_sh, b_sh, diff_sh, diff_nxt;
   logic              carry, bout_r, ovf_r, ovf_nxt;
   logic              fa_sum, fa_cout;

   // Subtraction as a + ~b + ~bin; carry register seeds with ~bin.
   full_adder_1bit u_fa (
      .a    (a_sh[0]),
      .b    (~b_sh[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign diff_nxt = {fa_sum, diff_sh[DATA_W-1:1]};
   assign ovf_nxt  = (a_sh[0] != b_sh[0]) && (fa_sum != a_sh[0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = BUSY;
         end
         BUSY: if (idx == LAST_IDX) state_next = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef SERIAL_SUB_CMP_EN
   logic bin_r, eq_r, lt_r, ltu_r;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         a_sh    <= '0;
         b_sh    <= '0;
         diff_sh <= '0;
         carry   <= 1'b0;
         bout_r  <= 1'b0;
         ovf_r   <= 1'b0;
`ifdef SERIAL_SUB_CMP_EN
         bin_r   <= 1'b0;
         eq_r    <= 1'b0;
         lt_r    <= 1'b0;
         ltu_r   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_sh  <= a;
               b_sh  <= b;
               carry <= ~bin;
               idx   <= '0;
`ifdef SERIAL_SUB_CMP_EN
               bin_r <= bin;
`endif
            end
            BUSY: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               diff_sh <= diff_nxt;
               carry   <= fa_cout;
               idx     <= idx + IDX_W'(1);
               // On the MSB slice the shifted-out operand bits are the captured MSBs.
               if (idx == LAST_IDX) begin
                  bout_r <= ~fa_cout;
                  ovf_r  <= ovf_nxt;
`ifdef SERIAL_SUB_CMP_EN
                  eq_r   <= (diff_nxt == '0) && fa_cout && !bin_r;
                  lt_r   <= fa_sum ^ ovf_nxt;
                  ltu_r  <= ~fa_cout;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign diff     = diff_sh;
   assign bout     = bout_r;
   assign overflow = ovf_r;
`ifdef SERIAL_SUB_CMP_EN
   assign eq  = eq_r;
   assign lt  = lt_r;
   assign ltu = ltu_r;
`endif

endmodule

// File: tb/tb_serial_subtractor_32bit.sv
// Scoreboard bench for serial_subtractor_32bit; flag checks follow SERIAL_SUB_CMP_EN.
module tb_serial_subtractor_32bit;

   localparam int unsigned DW = 32;

   typedef struct {
      logic [DW-1:0] diff;
      logic          bout;
      logic          ovf;
      logic          eq;
      logic          lt;
      logic          ltu;
   } exp_t;

   logic          clk, rst_n;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] a, b, diff;
   logic          bin, bout, overflow;
`ifdef SERIAL_SUB_CMP_EN
   logic          eq, lt, ltu;
`endif

   int   nchk = 0;
   int   nerr = 0;
   exp_t q[$];

   serial_subtractor_32bit #(.DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .overflow  (overflow)
`ifdef SERIAL_SUB_CMP_EN
     ,.eq        (eq),
      .lt        (lt),
      .ltu       (ltu)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [DW-1:0] ma, input logic [DW-1:0] mb, input logic mbin);
      exp_t        e;
      logic [DW:0] r;
      r      = {1'b0, ma} - {1'b0, mb} - {{DW{1'b0}}, mbin};
      e.diff = r[DW-1:0];
      e.bout = r[DW];
      e.ovf  = (ma[DW-1] != mb[DW-1]) && (e.diff[DW-1] != ma[DW-1]);
      e.eq   = (e.diff == '0) && !e.bout && !mbin;
      e.lt   = e.diff[DW-1] ^ e.ovf;
      e.ltu  = e.bout;
      return e;
   endfunction

   task automatic accept(input logic [DW-1:0] ta, input logic [DW-1:0] tb, input logic tbin);
      a        = ta;
      b        = tb;
      bin      = tbin;
      in_valid = 1'b1;
      #1;
      chk("in_ready_idle", in_ready, 1'b1);
      @(posedge clk);
      q.push_back(model(ta, tb, tbin));
      #1;
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      bin      = 1'($urandom);
   endtask

   task automatic wait_done();
      int n;
      for (n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (n == 3) begin
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
         end
         if (n == 4) in_valid = 1'b0;
         if (n == 5) chk("in_ready_busy", in_ready, 1'b0);
         if (out_valid) break;
      end
      chk("latency", 64'(n), 64'(DW));
   endtask

   task automatic compare(input string tag, input exp_t e);
      chk({tag, "_diff"}, diff, e.diff);
      chk({tag, "_bout"}, bout, e.bout);
      chk({tag, "_ovf"}, overflow, e.ovf);
`ifdef SERIAL_SUB_CMP_EN
      chk({tag, "_eq"}, eq, e.eq);
      chk({tag, "_lt"}, lt, e.lt);
      chk({tag, "_ltu"}, ltu, e.ltu);
`endif
   endtask

   task automatic collect(input string tag, input int hold);
      exp_t e;
      chk({tag, "_sb_nonempty"}, 64'(q.size() > 0), 64'(1));
      if (q.size() > 0) e = q.pop_front();
      else e = '{default: '0};
      for (int k = 0; k < hold; k++) begin
         chk({tag, "_hold_valid"}, out_valid, 1'b1);
         chk({tag, "_hold_ready"}, in_ready, 1'b0);
         compare({tag, "_hold"}, e);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      #1;
      chk({tag, "_consume_in_ready"}, in_ready, 1'b0);
      chk({tag, "_out_valid"}, out_valid, 1'b1);
      compare(tag, e);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_post_valid"}, out_valid, 1'b0);
      chk({tag, "_post_ready"}, in_ready, 1'b1);
   endtask

   task automatic run(input string tag, input logic [DW-1:0] ta, input logic [DW-1:0] tb,
                      input logic tbin, input int hold);
      accept(ta, tb, tbin);
      wait_done();
      collect(tag, hold);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      bin       = 1'b0;
      #2;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_diff", diff, '0);
      chk("rst_bout", bout, 1'b0);
      chk("rst_ovf", overflow, 1'b0);

      // Release between edges; the next rising edge must accept.
      @(negedge clk);
      rst_n = 1'b1;
      run("five_minus_three", 32'd5, 32'd3, 1'b0, 0);
      run("zero_minus_one", 32'd0, 32'd1, 1'b0, 0);
      run("seven_seven_bin", 32'd7, 32'd7, 1'b1, 0);
      run("min_minus_one", 32'h8000_0000, 32'd1, 1'b0, 0);
      run("backpressure", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 5);

      // Reset at bit 10 of BUSY: outputs must drop without a clock edge.
      accept(32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_diff", diff, '0);
      chk("midrst_bout", bout, 1'b0);
      chk("midrst_ovf", overflow, 1'b0);
      void'(q.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         chk("after_rst_no_valid", out_valid, 1'b0);
      end
      @(negedge clk);
      run("after_reset", 32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 0);

      run("three_minus_five", 32'd3, 32'd5, 1'b0, 0);
      run("ones_minus_one", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
      run("equal_ops", 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0, 0);
      run("max_minus_min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 2);
      for (int i = 0; i < 4; i++) begin
         run("random", 32'($urandom), 32'($urandom), 1'($urandom), i);
      end

      chk("sb_drained", 64'(q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
